// File: rtl/vector_writeback_sequencer.sv
// Serialises multi-lane vector results into a single register-file write port,
// one lane per cycle, and flags read-after-write hazards on pending lanes.
module vector_writeback_sequencer #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0]       in_base_addr,
  input  logic [CNT_W-1:0]        in_count,
  output logic [ADDR_W-1:0]       write_addr,
  output logic [DATA_W-1:0]       write_data,
  output logic                    write_enable,
  output logic                    busy,
  input  logic [ADDR_W-1:0]       chk_addr1,
  input  logic [ADDR_W-1:0]       chk_addr2,
  output logic                    hazard1,
  output logic                    hazard2
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [LANES*DATA_W-1:0]   buf_q, buf_d;
  logic [ADDR_W-1:0]         base_q, base_d;
  logic [CNT_W-1:0]          n_q, n_d;
  logic [CNT_W-1:0]          k_q, k_d;
  logic [ADDR_W-1:0]         waddr_q, waddr_d;
  logic [DATA_W-1:0]         wdata_q, wdata_d;
  logic                      we_q, we_d;

  logic [CNT_W-1:0]          n_eff;
  logic                      last_lane;
  logic                      accept;
  logic [DATA_W-1:0]         next_lane;
  logic [ADDR_W-1:0]         next_addr;
  logic [ADDR_W-1:0]         lane_addr;

  assign n_eff     = (in_count > CNT_W'(LANES)) ? CNT_W'(LANES) : in_count;
  assign last_lane = (state_q == DRAIN) && (k_q == n_q - CNT_W'(1));
  assign in_ready  = !rst && ((state_q == IDLE) || last_lane);
  assign accept    = in_valid && in_ready;
  assign busy      = !rst && (state_q == DRAIN);

  assign write_addr   = waddr_q;
  assign write_data   = wdata_q;
  assign write_enable = we_q;

  // Write port outputs are precomputed for the next cycle from the next-state
  // values, so the register file sees flop outputs stable for a whole cycle.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    base_d    = base_q;
    n_d       = n_q;
    k_d       = k_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    next_lane = '0;
    next_addr = '0;

    case (state_q)
      IDLE: begin
        if (accept && (n_eff != '0)) begin
          buf_d   = in_data;
          base_d  = in_base_addr;
          n_d     = n_eff;
          k_d     = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_lane) begin
          if (accept && (n_eff != '0)) begin
            buf_d  = in_data;
            base_d = in_base_addr;
            n_d    = n_eff;
            k_d    = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          k_d = k_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == DRAIN) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (k_d == CNT_W'(i)) next_lane = buf_d[i*DATA_W +: DATA_W];
      end
      next_addr = base_d + ADDR_W'(k_d);
      waddr_d   = next_addr;
      wdata_d   = next_lane;
      we_d      = (next_addr != '1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      base_q  <= '0;
      n_q     <= '0;
      k_q     <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      base_q  <= base_d;
      n_q     <= n_d;
      k_q     <= k_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  // Pending lanes are k..n-1 inclusive of the one currently presented.
  always_comb begin
    hazard1   = 1'b0;
    hazard2   = 1'b0;
    lane_addr = '0;
    if (!rst && (state_q == DRAIN)) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        lane_addr = base_q + ADDR_W'(j);
        if ((CNT_W'(j) >= k_q) && (CNT_W'(j) < n_q)) begin
          if ((chk_addr1 != '1) && (lane_addr == chk_addr1)) hazard1 = 1'b1;
          if ((chk_addr2 != '1) && (lane_addr == chk_addr2)) hazard2 = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_writeback_sequencer.sv
// Directed bench for vector_writeback_sequencer with a behavioural 32 x 8-bit
// register file that commits on the falling edge and hard-wires r31 to zero.
module tb_vector_writeback_sequencer;

  localparam int LANES  = 4;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_data;
  logic [ADDR_W-1:0]       in_base_addr;
  logic [CNT_W-1:0]        in_count;
  logic [ADDR_W-1:0]       write_addr;
  logic [DATA_W-1:0]       write_data;
  logic                    write_enable;
  logic                    busy;
  logic [ADDR_W-1:0]       chk_addr1;
  logic [ADDR_W-1:0]       chk_addr2;
  logic                    hazard1;
  logic                    hazard2;

  int unsigned n_checks;
  int unsigned n_errors;

  logic [DATA_W-1:0] rf [32];
  logic              rf_clear;

  vector_writeback_sequencer #(
    .LANES (LANES),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_base_addr(in_base_addr),
    .in_count    (in_count),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .write_enable(write_enable),
    .busy        (busy),
    .chk_addr1   (chk_addr1),
    .chk_addr2   (chk_addr2),
    .hazard1     (hazard1),
    .hazard2     (hazard2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (write_enable && (write_addr != 5'd31)) begin
      rf[write_addr] <= write_data;
    end
  end

  function automatic logic [DATA_W-1:0] rf_read(input logic [ADDR_W-1:0] a);
    return (a == 5'd31) ? '0 : rf[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt,
                      input logic [LANES*DATA_W-1:0] data);
    in_valid     = 1'b1;
    in_base_addr = base;
    in_count     = cnt;
    in_data      = data;
  endtask

  logic [ADDR_W-1:0] exp_addr [4];
  logic [DATA_W-1:0] exp_data [4];
  logic              exp_we   [4];
  int unsigned       we_count;

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rf_clear     = 1'b1;
    rst          = 1'b1;
    in_valid     = 1'b1;
    in_base_addr = 5'd3;
    in_count     = 4'd2;
    in_data      = 32'hDEAD_BEEF;
    chk_addr1    = '0;
    chk_addr2    = '0;

    // Reset held for two edges with in_valid asserted
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_we", write_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", write_addr, 0);
    check("rst_data", write_data, 0);
    in_valid = 1'b0;
    rst      = 1'b0;
    rf_clear = 1'b0;
    #1;
    check("post_rst_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);

    // Basic four-lane vector
    send(5'd4, 4'd4, 32'h4433_2211);
    tick();
    in_valid = 1'b0;
    exp_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      check("basic_addr", write_addr, 4 + i);
      check("basic_data", write_data, exp_data[i]);
      check("basic_we", write_enable, 1);
      check("basic_busy", busy, 1);
      tick();
    end
    check("basic_done_busy", busy, 0);
    check("basic_done_we", write_enable, 0);
    check("basic_hold_addr", write_addr, 7);
    check("basic_hold_data", write_data, 8'h44);
    for (int i = 0; i < 4; i++) check("basic_rf", rf_read(ADDR_W'(4 + i)), exp_data[i]);

    // Address wrap through the hard-zero register
    send(5'd30, 4'd4, 32'hA3A2_A1A0);
    tick();
    in_valid = 1'b0;
    exp_addr = '{5'd30, 5'd31, 5'd0, 5'd1};
    exp_data = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    exp_we   = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      check("wrap_addr", write_addr, exp_addr[i]);
      check("wrap_data", write_data, exp_data[i]);
      check("wrap_we", write_enable, exp_we[i]);
      tick();
    end
    check("wrap_r31", rf_read(5'd31), 0);
    check("wrap_r30", rf_read(5'd30), 8'hA0);
    check("wrap_r0", rf_read(5'd0), 8'hA2);
    check("wrap_r1", rf_read(5'd1), 8'hA3);

    // Zero-count handshake
    send(5'd20, 4'd0, 32'h5555_5555);
    #1;
    check("zero_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("zero_busy", busy, 0);
    check("zero_we", write_enable, 0);
    check("zero_ready_after", in_ready, 1);
    tick();
    check("zero_r20", rf_read(5'd20), 0);

    // Count above LANES is clamped
    send(5'd10, 4'd7, 32'h0403_0201);
    tick();
    in_valid = 1'b0;
    we_count = 0;
    for (int i = 0; i < 6; i++) begin
      if (write_enable) we_count++;
      tick();
    end
    check("clamp_writes", we_count, 4);
    check("clamp_busy", busy, 0);
    check("clamp_r13", rf_read(5'd13), 8'h04);
    check("clamp_r14", rf_read(5'd14), 0);

    // Back-to-back vectors with no bubble
    send(5'd8, 4'd2, 32'h0000_8281);
    tick();
    check("b2b_addr0", write_addr, 8);
    check("b2b_data0", write_data, 8'h81);
    check("b2b_ready0", in_ready, 0);
    tick();
    check("b2b_addr1", write_addr, 9);
    check("b2b_data1", write_data, 8'h82);
    send(5'd16, 4'd2, 32'h0000_9291);
    #1;
    check("b2b_ready1", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("b2b_addr2", write_addr, 16);
    check("b2b_data2", write_data, 8'h91);
    check("b2b_we2", write_enable, 1);
    tick();
    check("b2b_addr3", write_addr, 17);
    check("b2b_data3", write_data, 8'h92);
    check("b2b_we3", write_enable, 1);
    tick();
    check("b2b_done_we", write_enable, 0);
    check("b2b_r9", rf_read(5'd9), 8'h82);
    check("b2b_r16", rf_read(5'd16), 8'h91);

    // Hazards while draining, then reset mid-drain
    chk_addr1 = 5'd4;
    #1;
    check("haz_idle", hazard1, 0);
    send(5'd4, 4'd4, 32'h8877_6655);
    tick();
    in_valid = 1'b0;
    tick();
    check("haz_k1_addr", write_addr, 5);
    chk_addr1 = 5'd4;
    chk_addr2 = 5'd6;
    #1;
    check("haz_done_lane", hazard1, 0);
    check("haz_pending", hazard2, 1);
    chk_addr1 = 5'd5;
    chk_addr2 = 5'd31;
    #1;
    check("haz_current", hazard1, 1);
    check("haz_r31", hazard2, 0);
    chk_addr1 = 5'd7;
    chk_addr2 = 5'd8;
    #1;
    check("haz_last", hazard1, 1);
    check("haz_beyond", hazard2, 0);
    tick();
    check("rstmid_addr", write_addr, 6);
    check("rstmid_we_k2", write_enable, 1);
    rst = 1'b1;
    tick();
    check("rstmid_we", write_enable, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_haz", hazard1, 0);
    rst = 1'b0;
    tick();
    tick();
    check("rstmid_we_later", write_enable, 0);
    check("rstmid_r6", rf_read(5'd6), 8'h77);
    check("rstmid_r7", rf_read(5'd7), 8'h44);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vector_writeback_sequencer.md
Name: vector_writeback_sequencer

Overview:
Writeback stage directly upstream of the 32 x 8-bit register file. It accepts one multi-lane vector result per handshake and serialises it into the register file's single write port, one lane per clock, to consecutive destination registers. It also reports read-after-write hazards for pending lanes so issue logic can stall reads of not-yet-written registers.

Parameters:
LANES, 4, number of 8-bit lanes per vector result (power of two, 2..8)
DATA_W, 8, lane / register width
ADDR_W, 5, register address width (32 registers; address 31 is the hard-zero register)
CNT_W, 4, width of in_count (must hold 0..LANES; default covers up to 8)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  vector result available
in_ready  output  1  sequencer can accept a vector this cycle
in_data  input  LANES*DATA_W  lane k at bits [k*DATA_W +: DATA_W]
in_base_addr  input  ADDR_W  destination register of lane 0
in_count  input  CNT_W  number of lanes to write
write_addr  output  ADDR_W  to register file write_addr
write_data  output  DATA_W  to register file write_data
write_enable  output  1  to register file write_enable
busy  output  1  high while lanes remain to be written
chk_addr1  input  ADDR_W  read address 1 to hazard-check
chk_addr2  input  ADDR_W  read address 2 to hazard-check
hazard1  output  1  chk_addr1 targets a pending lane
hazard2  output  1  chk_addr2 targets a pending lane

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- States: IDLE, DRAIN. Registered: state, lane buffer, base, count n, lane index k.
- Reset (rst high at rising edge): state=IDLE, k=0, n=0. While rst high: in_ready=0, write_enable=0, write_addr=0, write_data=0, busy=0, hazard1/2=0.
- Accept = in_valid && in_ready at a rising edge. in_count is clamped to LANES, giving n_eff.
- IDLE: in_ready=1. On accept with n_eff>0: latch data, base and n_eff; k=0; go to DRAIN. On accept with n_eff=0: handshake completes, no writes, remain IDLE.
- DRAIN, index k: write_addr=(base+k) mod 32 (5-bit wrap), write_data=lane k, write_enable=1 unless write_addr==31. At address 31 write_enable=0, but the slot still consumes one cycle. k increments each cycle. After lane n-1, go to IDLE.
- Latency: accept at edge t -> lane 0 is presented from edge t until edge t+1, and the register file commits it on the intervening falling edge. n lanes take exactly n cycles.
- Outputs are driven from registered state only: stable across the full cycle, so valid at the register file's falling-edge write.
- Back-to-back: in_ready=1 in the cycle where k==n-1. An accept there loads the new vector, and lane 0 of the new vector is presented the very next cycle (no bubble). An accept of n_eff=0 there goes to IDLE.
- busy = (state==DRAIN).
- Hazard: hazardX=1 iff state==DRAIN, chkX != 31, and chkX equals (base+j) mod 32 for some j in [k, n-1]. The lane currently presented counts as pending. Combinational from state and chk inputs.
- Outside DRAIN: write_enable=0, and write_addr/write_data hold their last value.
- Reset mid-DRAIN: remaining lanes are discarded, and write_enable=0 from the cycle after the reset edge.

Test Plan:
1. Assert rst 2 cycles, in_valid=1 -> in_ready=0, write_enable=0, busy=0, no accept. Release rst -> in_ready=1.
2. Accept base=4, count=4, lanes 0x11,0x22,0x33,0x44 -> next 4 cycles present addr 4/0x11, 5/0x22, 6/0x33, 7/0x44 with write_enable=1. busy high exactly 4 cycles. Register file reads r4..r7 return 0x11..0x44.
3. Wrap: base=30, count=4, lanes 0xA0..0xA3 -> addrs 30,31,0,1. write_enable=1,0,1,1. r31 still reads 0; r0=0xA2, r1=0xA3.
4. Count edge cases: count=0 -> in_ready handshake, busy stays 0, no writes. count=7 with LANES=4 -> exactly 4 writes.
5. Back-to-back: hold in_valid with base=8 count=2, then base=16 count=2 -> writes to 8, 9, 16, 17 on 4 consecutive cycles. Second accept occurs in the cycle presenting addr 9.
6. Hazard and reset: during base=4 count=4 at k=1, chk_addr1=4 -> hazard1=0; chk_addr2=6 -> hazard2=1; chk_addr=31 -> 0. Assert rst at k=2 -> write_enable=0 next cycle, r7 unchanged.
